// File: rtl/rv_alu_pkg.sv
// Shared decode constants, operation and FSM state types for the rv_alu_mc execute unit.
package rv_alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Immediate bits above the shift amount for logical and arithmetic shifts
    localparam logic [5:0] SHT_LOGIC = 6'b000000;
    localparam logic [5:0] SHT_ARITH = 6'b010000;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } alu_op_e;

    typedef enum logic [0:0] {IDLE, DIV} alu_state_e;

    // M-extension funct3 mapping under funct7 0000001
    function automatic alu_op_e muldiv_op(input logic [2:0] f3);
        alu_op_e op;
        unique case (f3)
            F3_ADD:  op = OP_MUL;
            F3_SLL:  op = OP_MULH;
            F3_SLT:  op = OP_MULHSU;
            F3_SLTU: op = OP_MULHU;
            F3_XOR:  op = OP_DIV;
            F3_SR:   op = OP_DIVU;
            F3_OR:   op = OP_REM;
            default: op = OP_REMU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_alu_div.sv
// Unsigned restoring radix-2 divider; XLEN iterations, the last one presented combinationally
// alongside done so the caller can register the result on that same edge.
module rv_alu_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] rem_q, quo_q, dsr_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   shifted, diff;
    logic            fits;
    logic [XLEN-1:0] rem_n, quo_n;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
        fits    = !diff[XLEN];
        rem_n   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_n   = {quo_q[XLEN-2:0], fits};
    end

    assign done      = (cnt_q == CW'(1));
    assign quotient  = quo_n;
    assign remainder = rem_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= CW'(XLEN);
        end else if (cnt_q != '0) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/rv_alu_mc.sv
// Handshaked RISC-V integer execute unit: R/I-type arithmetic with a registered result.
// Defining RV_ALU_M_EXT_EN adds single-cycle multiply and an iterative divider.
module rv_alu_mc
    import rv_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [5:0]      shamt_hi;
    logic            shamt_ok;
    logic [XLEN-1:0] imm, op_a, op_b;
    logic [SHW-1:0]  shamt;
    logic            use_imm, illegal, is_div, accept;
    alu_op_e         op;
    logic [XLEN-1:0] alu_res;
    logic            unused_rs_idx;

    alu_state_e      state_q, state_d;
    logic            out_valid_q, out_valid_d, out_illegal_q, out_illegal_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [4:0]      out_rd_q, out_rd_d;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign shamt_hi = in_instr[31:26];
    // RV32 has only a 5-bit shamt, so bit 25 must stay clear there
    assign shamt_ok = (XLEN == 64) || !in_instr[25];
    assign imm      = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign unused_rs_idx = ^in_instr[19:15];

    always_comb begin
        op      = OP_ADD;
        illegal = 1'b0;
        use_imm = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        F3_ADD:  op = OP_ADD;
                        F3_SLL:  op = OP_SLL;
                        F3_SLT:  op = OP_SLT;
                        F3_SLTU: op = OP_SLTU;
                        F3_XOR:  op = OP_XOR;
                        F3_SR:   op = OP_SRL;
                        F3_OR:   op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    op = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    op = OP_SRA;
`ifdef RV_ALU_M_EXT_EN
                end else if (funct7 == F7_MULDIV) begin
                    op = muldiv_op(funct3);
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                unique case (funct3)
                    F3_ADD:  op = OP_ADD;
                    F3_SLT:  op = OP_SLT;
                    F3_SLTU: op = OP_SLTU;
                    F3_XOR:  op = OP_XOR;
                    F3_OR:   op = OP_OR;
                    F3_AND:  op = OP_AND;
                    F3_SLL: begin
                        op      = OP_SLL;
                        illegal = !(shamt_ok && shamt_hi == SHT_LOGIC);
                    end
                    default: begin
                        op      = (shamt_hi == SHT_ARITH) ? OP_SRA : OP_SRL;
                        illegal = !(shamt_ok && (shamt_hi == SHT_LOGIC || shamt_hi == SHT_ARITH));
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign op_a   = in_rs1;
    assign op_b   = use_imm ? imm : in_rs2;
    assign shamt  = op_b[SHW-1:0];
`ifdef RV_ALU_M_EXT_EN
    assign is_div = !illegal && (op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU);

    // Product of sign/zero-extended operands; modulo 2^(2*XLEN) it is exact for all variants
    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN-1:0] mul_p;
    always_comb begin
        mul_a = {(op == OP_MULH || op == OP_MULHSU) && op_a[XLEN-1], op_a};
        mul_b = {(op == OP_MULH) && op_b[XLEN-1], op_b};
        mul_p = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
    end
`else
    assign is_div = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
`ifdef RV_ALU_M_EXT_EN
            OP_MUL:  alu_res = mul_p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res = mul_p[2*XLEN-1:XLEN];
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef RV_ALU_M_EXT_EN
    logic            div_start, div_done, div_signed, a_neg, b_neg;
    logic [XLEN-1:0] div_q, div_r, div_res;
    logic [XLEN-1:0] dividend_q;
    logic [4:0]      pend_rd_q;
    logic            is_rem_q, div_zero_q, neg_quo_q, neg_rem_q;

    assign div_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_neg      = div_signed && op_a[XLEN-1];
    assign b_neg      = div_signed && op_b[XLEN-1];
    assign div_start  = accept && is_div;

    rv_alu_div #(
        .XLEN (XLEN)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (a_neg ? -op_a : op_a),
        .divisor   (b_neg ? -op_b : op_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Most-negative / -1 falls out of the magnitude path; only divide-by-zero needs overriding
    always_comb begin
        if (div_zero_q) begin
            div_res = is_rem_q ? dividend_q : '1;
        end else if (is_rem_q) begin
            div_res = neg_rem_q ? -div_r : div_r;
        end else begin
            div_res = neg_quo_q ? -div_q : div_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_q <= '0;
            pend_rd_q  <= '0;
            is_rem_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (div_start) begin
            dividend_q <= op_a;
            pend_rd_q  <= rd;
            is_rem_q   <= (op == OP_REM) || (op == OP_REMU);
            div_zero_q <= (op_b == '0);
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
        end
    end
`endif

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (is_div) begin
                state_d = DIV;
            end else begin
                out_valid_d   = 1'b1;
                out_result_d  = illegal ? '0 : alu_res;
                out_rd_d      = rd;
                out_illegal_d = illegal;
            end
        end
`ifdef RV_ALU_M_EXT_EN
        if (state_q == DIV && div_done) begin
            state_d       = IDLE;
            out_valid_d   = 1'b1;
            out_result_d  = div_res;
            out_rd_d      = pend_rd_q;
            out_illegal_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_rv_alu_mc.sv
// Randomised self-checking bench for rv_alu_mc (XLEN=32) against an arithmetic reference model.
module tb_rv_alu_mc;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_rs1, in_rs2, out_result;
    logic [4:0]  out_rd;
    int          n_cmp = 0;
    int          n_err = 0;

    rv_alu_mc #(
        .XLEN (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    // Reference: result, illegal flag and expected latency straight from the ISA rules
    function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic ill, output int lat);
        logic [6:0]      f7;
        logic [2:0]      f3;
        logic [31:0]     imm;
        longint          sa, sb;
        longint unsigned ua, ub;
        f7  = ins[31:25];
        f3  = ins[14:12];
        imm = {{20{ins[31]}}, ins[31:20]};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        res = 32'b0;
        ill = 1'b0;
        lat = 1;
        if (ins[6:0] == 7'b0110011) begin
            case ({f7, f3})
                {7'b0000000, 3'b000}: res = a + b;
                {7'b0100000, 3'b000}: res = a - b;
                {7'b0000000, 3'b001}: res = a << b[4:0];
                {7'b0000000, 3'b010}: res = (sa < sb) ? 32'd1 : 32'd0;
                {7'b0000000, 3'b011}: res = (a < b) ? 32'd1 : 32'd0;
                {7'b0000000, 3'b100}: res = a ^ b;
                {7'b0000000, 3'b101}: res = a >> b[4:0];
                {7'b0100000, 3'b101}: res = 32'(sa >>> b[4:0]);
                {7'b0000000, 3'b110}: res = a | b;
                {7'b0000000, 3'b111}: res = a & b;
`ifdef RV_ALU_M_EXT_EN
                {7'b0000001, 3'b000}: res = 32'(sa * sb);
                {7'b0000001, 3'b001}: res = 32'((sa * sb) >>> 32);
                {7'b0000001, 3'b010}: res = 32'((sa * longint'(ub)) >>> 32);
                {7'b0000001, 3'b011}: res = 32'((ua * ub) >> 32);
                {7'b0000001, 3'b100}: begin
                    lat = 33;
                    if (b == 0) res = '1;
                    else if (a == 32'h8000_0000 && b == '1) res = a;
                    else res = 32'(sa / sb);
                end
                {7'b0000001, 3'b101}: begin
                    lat = 33;
                    res = (b == 0) ? '1 : a / b;
                end
                {7'b0000001, 3'b110}: begin
                    lat = 33;
                    if (b == 0) res = a;
                    else if (a == 32'h8000_0000 && b == '1) res = 0;
                    else res = 32'(sa % sb);
                end
                {7'b0000001, 3'b111}: begin
                    lat = 33;
                    res = (b == 0) ? a : a % b;
                end
`endif
                default: ill = 1'b1;
            endcase
        end else if (ins[6:0] == 7'b0010011) begin
            case (f3)
                3'b000: res = a + imm;
                3'b010: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'b011: res = (a < imm) ? 32'd1 : 32'd0;
                3'b100: res = a ^ imm;
                3'b110: res = a | imm;
                3'b111: res = a & imm;
                3'b001: if (f7 == 7'b0000000) res = a << ins[24:20]; else ill = 1'b1;
                default: begin
                    if (f7 == 7'b0000000) res = a >> ins[24:20];
                    else if (f7 == 7'b0100000) res = 32'(sa >>> ins[24:20]);
                    else ill = 1'b1;
                end
            endcase
        end else begin
            ill = 1'b1;
        end
        if (ill) res = 32'b0;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                w[6:0] = 7'b0110011;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'b0000000;
                    1: w[31:25] = 7'b0100000;
                    2: w[31:25] = 7'b0000001;
                    default: ;
                endcase
            end
            4, 5, 6, 7: begin
                w[6:0] = 7'b0010011;
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'b0000000;
                    1: w[31:25] = 7'b0100000;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return w;
    endfunction

    // One transaction with OutReady held high; checks latency, result, rd and illegal flag
    task automatic do_op(input string name, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] got);
        logic [31:0] er;
        logic        ei;
        int          el, lat;
        model(ins, a, b, er, ei, el);
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_rs1    = a;
        in_rs2    = b;
        out_ready = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got = out_result;
        n_cmp++;
        if (lat != el) begin
            n_err++;
            $display("FAIL %s_latency: got %0d want %0d (instr %h)", name, lat, el, ins);
        end
        n_cmp++;
        if (out_result !== er) begin
            n_err++;
            $display("FAIL %s_result: got %h want %h (instr %h a %h b %h)", name, out_result,
                     er, ins, a, b);
        end
        n_cmp++;
        if (out_rd !== ins[11:7]) begin
            n_err++;
            $display("FAIL %s_rd: got %0d want %0d", name, out_rd, ins[11:7]);
        end
        n_cmp++;
        if (out_illegal !== ei) begin
            n_err++;
            $display("FAIL %s_illegal: got %b want %b (instr %h)", name, out_illegal, ei, ins);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b0;
        #13;
        n_cmp++;
        if ({out_valid, out_result, out_rd, out_illegal} !== 39'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b r=%h rd=%0d ill=%b want all 0", out_valid,
                     out_result, out_rd, out_illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] got;
        do_op("add_x3", r_ins(7'b0000000, 3'b000, 5'd3), 32'd5, 32'd7, got);
        n_cmp++;
        if (got !== 32'd12) begin
            n_err++;
            $display("FAIL add_x3_const: got %h want 0000000c", got);
        end
        do_op("srai4", i_ins({7'b0100000, 5'd4}, 3'b101, 5'd9), 32'h8000_0000, 32'h0, got);
        n_cmp++;
        if (got !== 32'hF800_0000) begin
            n_err++;
            $display("FAIL srai4_const: got %h want f8000000", got);
        end
        do_op("sltu", r_ins(7'b0000000, 3'b011, 5'd4), 32'd1, 32'hFFFF_FFFF, got);
        n_cmp++;
        if (got !== 32'd1) begin
            n_err++;
            $display("FAIL sltu_const: got %h want 00000001", got);
        end
        do_op("slt", r_ins(7'b0000000, 3'b010, 5'd5), 32'd1, 32'hFFFF_FFFF, got);
        n_cmp++;
        if (got !== 32'd0) begin
            n_err++;
            $display("FAIL slt_const: got %h want 00000000", got);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] got;
        do_op("ill_load", {25'h1ABCDE, 7'b0000011}, 32'd3, 32'd4, got);
        do_op("ill_xor_alt", r_ins(7'b0100000, 3'b100, 5'd7), 32'hF0F0, 32'h0FF0, got);
        do_op("ill_or_alt", r_ins(7'b0100000, 3'b110, 5'd8), 32'hF0F0, 32'h0FF0, got);
        do_op("ill_slli_b25", i_ins({7'b0000001, 5'd3}, 3'b001, 5'd10), 32'h1, 32'h0, got);
`ifndef RV_ALU_M_EXT_EN
        do_op("ill_mul", r_ins(7'b0000001, 3'b000, 5'd11), 32'd6, 32'd7, got);
        n_cmp++;
        if (out_illegal !== 1'b1) begin
            n_err++;
            $display("FAIL ill_mul_flag: got %b want 1", out_illegal);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] e1, e2, i1, i2;
        logic        ill;
        int          lat;
        i1 = r_ins(7'b0000000, 3'b100, 5'd12);
        i2 = r_ins(7'b0000000, 3'b000, 5'd13);
        model(i1, 32'hDEAD_BEEF, 32'h1234_5678, e1, ill, lat);
        model(i2, 32'd100, 32'd23, e2, ill, lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = i1;
        in_rs1    = 32'hDEAD_BEEF;
        in_rs2    = 32'h1234_5678;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_instr = i2;
        in_rs1   = 32'd100;
        in_rs2   = 32'd23;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== e1 ||
                out_rd !== 5'd12) begin
                n_err++;
                $display("FAIL stall_hold%0d: got rdy=%b v=%b r=%h rd=%0d want 0 1 %h 12", c,
                         in_ready, out_valid, out_result, out_rd, e1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== e2 || out_rd !== 5'd13) begin
            n_err++;
            $display("FAIL stall_queued: got v=%b r=%h rd=%0d want 1 %h 13", out_valid,
                     out_result, out_rd, e2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r[8];
        logic [4:0]  exp_rd[8];
        logic [31:0] ins, a, b;
        logic [2:0]  f3;
        logic        ill;
        int          lat;
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_result !== exp_r[i-1] ||
                    out_rd !== exp_rd[i-1]) begin
                    n_err++;
                    $display("FAIL b2b_%0d: got v=%b r=%h rd=%0d want 1 %h %0d", i - 1, out_valid,
                             out_result, out_rd, exp_r[i-1], exp_rd[i-1]);
                end
            end
            if (i < 8) begin
                f3  = 3'($urandom);
                ins = r_ins(((f3 == 3'b000 || f3 == 3'b101) && $urandom_range(0, 1) == 1) ?
                            7'b0100000 : 7'b0000000, f3, 5'($urandom));
                a   = rand_opnd();
                b   = rand_opnd();
                model(ins, a, b, exp_r[i], ill, lat);
                exp_rd[i] = ins[11:7];
                in_valid  = 1'b1;
                in_instr  = ins;
                in_rs1    = a;
                in_rs2    = b;
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int i = 0; i < 60; i++) begin
            do_op("rand", rand_instr(), rand_opnd(), rand_opnd(), got);
        end
    endtask

`ifdef RV_ALU_M_EXT_EN
    task automatic test_mext();
        logic [31:0] got;
        do_op("div_m7_2", r_ins(7'b0000001, 3'b100, 5'd14), -32'sd7, 32'd2, got);
        n_cmp++;
        if (got !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL div_m7_2_const: got %h want fffffffd", got);
        end
        do_op("rem_m7_2", r_ins(7'b0000001, 3'b110, 5'd15), -32'sd7, 32'd2, got);
        n_cmp++;
        if (got !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL rem_m7_2_const: got %h want ffffffff", got);
        end
        do_op("divu_by0", r_ins(7'b0000001, 3'b101, 5'd16), 32'd9, 32'd0, got);
        n_cmp++;
        if (got !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL divu_by0_const: got %h want ffffffff", got);
        end
        do_op("rem_by0", r_ins(7'b0000001, 3'b110, 5'd17), -32'sd9, 32'd0, got);
        do_op("div_ovf", r_ins(7'b0000001, 3'b100, 5'd18), 32'h8000_0000, 32'hFFFF_FFFF, got);
        n_cmp++;
        if (got !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL div_ovf_const: got %h want 80000000", got);
        end
        do_op("rem_ovf", r_ins(7'b0000001, 3'b110, 5'd19), 32'h8000_0000, 32'hFFFF_FFFF, got);
        do_op("mulh_m1", r_ins(7'b0000001, 3'b001, 5'd20), 32'hFFFF_FFFF, 32'hFFFF_FFFF, got);
        n_cmp++;
        if (got !== 32'h0) begin
            n_err++;
            $display("FAIL mulh_m1_const: got %h want 00000000", got);
        end
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        logic [31:0] got;
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = r_ins(7'b0000001, 3'b101, 5'd21);
        in_rs1    = 32'd1000;
        in_rs2    = 32'd7;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        seen  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_div_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_div_no_output: got out_valid 1 want 0");
        end
        do_op("post_rst_add", r_ins(7'b0000000, 3'b000, 5'd22), 32'd40, 32'd2, got);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_stall();
        test_back_to_back();
`ifdef RV_ALU_M_EXT_EN
        test_mext();
        test_reset_mid_div();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
